// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction width, default loader address width, loader state encodings.
package cpu_defs;
  localparam int INSTR_W    = 16;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    WRITE   = 2'd2,
    RUN     = 2'd3
  } ldr_state_t;
endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse in the cycle a level input first reads high.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;
endmodule

// File: rtl/prog_loader.sv
// Program loader: assembles 16-bit words from two switch bytes and writes them to instruction memory.
// Optional running XOR checksum of committed words when LOADER_CHECKSUM_EN is defined.
module prog_loader
  import cpu_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         sw_data,
  input  logic               btn_lo,
  input  logic               btn_hi,
  input  logic               btn_run,
  output logic               mem_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_din,
  input  logic               mem_ready,
  output logic               cpu_hold,
  output logic [ADDR_W:0]    word_count,
  output logic               full,
  output logic               err,
  output logic [INSTR_W-1:0] checksum
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic lo_p, hi_p, run_p;

  edge_pulse u_lo  (.clk(clk), .reset(reset), .level(btn_lo),  .pulse(lo_p));
  edge_pulse u_hi  (.clk(clk), .reset(reset), .level(btn_hi),  .pulse(hi_p));
  edge_pulse u_run (.clk(clk), .reset(reset), .level(btn_run), .pulse(run_p));

  ldr_state_t        state, state_n;
  logic [7:0]        lo_q, lo_n;
  logic [INSTR_W-1:0] din_n;
  logic [ADDR_W:0]   cnt_n;
  logic              err_n;
  logic              pend, pend_n;
  logic              xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD_LO;
      lo_q       <= '0;
      mem_din    <= '0;
      word_count <= '0;
      err        <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_n;
      lo_q       <= lo_n;
      mem_din    <= din_n;
      word_count <= cnt_n;
      err        <= err_n;
      pend       <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    lo_n    = lo_q;
    din_n   = mem_din;
    cnt_n   = word_count;
    err_n   = err;
    pend_n  = pend;
    xfer    = 1'b0;
    unique case (state)
      LOAD_LO: begin
        // A run request deferred from WRITE is honoured here, ahead of any new edges.
        if (run_p || pend) begin
          state_n = RUN;
          pend_n  = 1'b0;
        end else if (hi_p) begin
          err_n = 1'b1;
        end else if (lo_p) begin
          lo_n    = sw_data;
          state_n = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (run_p) begin
          state_n = RUN;
        end else if (hi_p) begin
          if (full) begin
            err_n   = 1'b1;
            state_n = LOAD_LO;
          end else begin
            din_n   = {sw_data, lo_q};
            state_n = WRITE;
          end
        end else if (lo_p) begin
          lo_n = sw_data;
        end
      end
      WRITE: begin
        if (run_p) pend_n = 1'b1;
        if (mem_ready) begin
          xfer    = 1'b1;
          cnt_n   = word_count + ONE;
          state_n = LOAD_LO;
        end
      end
      RUN: begin
        if (lo_p) state_n = LOAD_LO;
      end
      default: state_n = LOAD_LO;
    endcase
  end

  // Address tracks the committed count; no writes are issued once full, so it never wraps.
  assign mem_addr = word_count[ADDR_W-1:0];
  assign mem_wr   = (state == WRITE);
  assign cpu_hold = (state != RUN);
  assign full     = (word_count == DEPTH_C);

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] cks;
  always_ff @(posedge clk) begin
    if (reset)     cks <= '0;
    else if (xfer) cks <= cks ^ mem_din;
  end
  assign checksum = cks;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (built with DEPTH=4 to reach the full boundary).
module tb_prog_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    sw_data;
  logic          btn_lo, btn_hi, btn_run;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_ready;
  logic          cpu_hold;
  logic [AW:0]   word_count;
  logic          full, err;
  logic [15:0]   checksum;

  int nt = 0;
  int nf = 0;

  prog_loader #(.ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sw_data(sw_data),
    .btn_lo(btn_lo), .btn_hi(btn_hi), .btn_run(btn_run),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ready(mem_ready),
    .cpu_hold(cpu_hold), .word_count(word_count), .full(full), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_lo = 0; btn_hi = 0; btn_run = 0; sw_data = 8'h00; mem_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic press_lo(input logic [7:0] b);
    sw_data = b; btn_lo = 1'b1; tick(); btn_lo = 1'b0;
  endtask

  task automatic press_hi(input logic [7:0] b);
    sw_data = b; btn_hi = 1'b1; tick(); btn_hi = 1'b0;
  endtask

  task automatic press_run();
    btn_run = 1'b1; tick(); btn_run = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] w);
    mem_ready = 1'b1;
    press_lo(w[7:0]);
    press_hi(w[15:8]);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_lo = 0; btn_hi = 0; btn_run = 0; sw_data = 8'h00; mem_ready = 1'b1;
    tick();
    nt++;
    if ({mem_wr, mem_addr, mem_din, cpu_hold, word_count, full, err, checksum} !==
        {1'b0, 8'h00, 16'h0000, 1'b1, 9'd0, 1'b0, 1'b0, 16'h0000}) begin
      nf++;
      $display("FAIL reset_state: wr=%b addr=%h din=%h hold=%b cnt=%0d full=%b err=%b cks=%h, need 0/00/0000/1/0/0/0/0000",
               mem_wr, mem_addr, mem_din, cpu_hold, word_count, full, err, checksum);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    mem_ready = 1'b1;
    press_lo(8'h05);
    press_hi(8'hD1);
    nt++;
    if ({mem_wr, mem_addr, mem_din} !== {1'b1, 8'h00, 16'hD105}) begin
      nf++;
      $display("FAIL basic_write: wr=%b addr=%h din=%h, need 1/00/D105", mem_wr, mem_addr, mem_din);
    end
    tick();
    nt++;
    if ({mem_wr, mem_addr, word_count} !== {1'b0, 8'h01, 9'd1}) begin
      nf++;
      $display("FAIL basic_done: wr=%b addr=%h cnt=%0d, need 0/01/1", mem_wr, mem_addr, word_count);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    mem_ready = 1'b0;
    press_lo(8'h5A);
    press_hi(8'hA5);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      nt++;
      if ({mem_wr, mem_addr, mem_din, word_count} !== {1'b1, 8'h00, 16'hA55A, 9'd0}) begin
        nf++;
        $display("FAIL wait_hold[%0d]: wr=%b addr=%h din=%h cnt=%0d, need 1/00/A55A/0",
                 i, mem_wr, mem_addr, mem_din, word_count);
      end
      tick();
    end
    nt++;
    if ({mem_wr, mem_addr, word_count} !== {1'b0, 8'h01, 9'd1}) begin
      nf++;
      $display("FAIL wait_done: wr=%b addr=%h cnt=%0d, need 0/01/1", mem_wr, mem_addr, word_count);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    mem_ready = 1'b0;
    press_lo(8'h11);
    press_hi(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nt++;
    if ({mem_wr, word_count} !== {1'b0, 9'd0}) begin
      nf++;
      $display("FAIL reset_mid_write: wr=%b cnt=%0d, need 0/0", mem_wr, word_count);
    end
  endtask

  task automatic test_err();
    do_reset();
    press_hi(8'h33);
    nt++;
    if ({err, mem_wr} !== {1'b1, 1'b0}) begin
      nf++;
      $display("FAIL err_hi_no_lo: err=%b wr=%b, need 1/0", err, mem_wr);
    end
    tick();
    write_word(16'h4321);
    nt++;
    if ({err, word_count, mem_addr} !== {1'b1, 9'd1, 8'h01}) begin
      nf++;
      $display("FAIL err_sticky: err=%b cnt=%0d addr=%h, need 1/1/01", err, word_count, mem_addr);
    end
  endtask

  task automatic test_full();
    do_reset();
    write_word(16'h0101);
    write_word(16'h0202);
    write_word(16'h0303);
    nt++;
    if (full !== 1'b0) begin
      nf++;
      $display("FAIL full_early: full=%b at cnt=%0d, need 0", full, word_count);
    end
    write_word(16'h0404);
    nt++;
    if ({full, word_count, mem_addr, err} !== {1'b1, 9'd4, 8'h04, 1'b0}) begin
      nf++;
      $display("FAIL full_set: full=%b cnt=%0d addr=%h err=%b, need 1/4/04/0", full, word_count, mem_addr, err);
    end
    press_lo(8'h55);
    press_hi(8'h66);
    nt++;
    if ({mem_wr, err, mem_addr, word_count} !== {1'b0, 1'b1, 8'h04, 9'd4}) begin
      nf++;
      $display("FAIL full_commit: wr=%b err=%b addr=%h cnt=%0d, need 0/1/04/4", mem_wr, err, mem_addr, word_count);
    end
    tick();
    nt++;
    if ({mem_wr, mem_addr} !== {1'b0, 8'h04}) begin
      nf++;
      $display("FAIL full_after: wr=%b addr=%h, need 0/04", mem_wr, mem_addr);
    end
  endtask

  task automatic test_run();
    do_reset();
    write_word(16'hAAAA);
    write_word(16'hBBBB);
    press_run();
    nt++;
    if (cpu_hold !== 1'b0) begin
      nf++;
      $display("FAIL run_release: hold=%b, need 0", cpu_hold);
    end
    tick();
    press_lo(8'h00);
    nt++;
    if ({cpu_hold, word_count} !== {1'b1, 9'd2}) begin
      nf++;
      $display("FAIL run_reload: hold=%b cnt=%0d, need 1/2", cpu_hold, word_count);
    end
    tick();
    press_lo(8'h77);
    press_hi(8'h88);
    nt++;
    if ({mem_wr, mem_addr, mem_din} !== {1'b1, 8'h02, 16'h8877}) begin
      nf++;
      $display("FAIL run_resume: wr=%b addr=%h din=%h, need 1/02/8877", mem_wr, mem_addr, mem_din);
    end
    tick();
  endtask

  task automatic test_deferred_run();
    do_reset();
    mem_ready = 1'b0;
    press_lo(8'h01);
    press_hi(8'h02);
    press_run();
    nt++;
    if ({mem_wr, cpu_hold} !== {1'b1, 1'b1}) begin
      nf++;
      $display("FAIL defer_in_write: wr=%b hold=%b, need 1/1", mem_wr, cpu_hold);
    end
    mem_ready = 1'b1;
    tick();
    tick();
    nt++;
    if ({cpu_hold, word_count} !== {1'b0, 9'd1}) begin
      nf++;
      $display("FAIL defer_taken: hold=%b cnt=%0d, need 0/1", cpu_hold, word_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    press_lo(8'h10);
    sw_data = 8'h20; btn_hi = 1'b1; btn_run = 1'b1;
    tick();
    btn_hi = 1'b0; btn_run = 1'b0;
    nt++;
    if ({mem_wr, cpu_hold, err} !== {1'b0, 1'b0, 1'b0}) begin
      nf++;
      $display("FAIL prio_run_hi: wr=%b hold=%b err=%b, need 0/0/0", mem_wr, cpu_hold, err);
    end
  endtask

  task automatic test_checksum();
    logic [15:0] exp;
    do_reset();
    write_word(16'h1234);
    write_word(16'h00FF);
`ifdef LOADER_CHECKSUM_EN
    exp = 16'h12CB;
`else
    exp = 16'h0000;
`endif
    nt++;
    if (checksum !== exp) begin
      nf++;
      $display("FAIL checksum: got %h, need %h", checksum, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_reset_mid_write();
    test_err();
    test_full();
    test_run();
    test_deferred_run();
    test_priority();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
